rotation_slicer: RTL and testbench



---
 rtl/rotation_pkg.sv | 17 +
 rtl/hall_edge_detect.sv | 29 ++
 rtl/rotation_slicer.sv | 147 ++++++++++++++
 tb/tb_rotation_slicer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rotation_pkg.sv
// Shared types and defaults for the rotation slicer: FSM state encoding,
// default slice/period widths and the synthetic revolution period.
package rotation_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rot_state_t;

  localparam int unsigned NB_SLICES_LOG2_DEF = 7;
  localparam int unsigned PERIOD_W_DEF       = 32;

  // One synthetic revolution: 128 slices of 66 cycles each.
  localparam int unsigned SIM_PERIOD = 128 * 66;

endpackage

// File: rtl/hall_edge_detect.sv
// Three-flop synchroniser for the asynchronous active-low hall sensor,
// producing a single-cycle pulse on each falling edge.
module hall_edge_detect (
  input  logic clk,
  input  logic nrst,
  input  logic hall_n_i,
  output logic fall_c
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= hall_n_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s3 is the older sample: high then low means the sensor just fell.
  assign fall_c = s3_q & ~s2_q;

endmodule

// File: rtl/rotation_slicer.sv
// Measures the revolution period from hall pulses and splits it into
// 2^NB_SLICES_LOG2 slices. Define ROTATION_SLICER_SIM_EN to replace the hall
// sensor with an internal revolution generator of SIM_PERIOD cycles.
module rotation_slicer
  import rotation_pkg::*;
#(
  parameter int unsigned NB_SLICES_LOG2 = NB_SLICES_LOG2_DEF,
  parameter int unsigned PERIOD_W       = PERIOD_W_DEF,
  parameter int unsigned MIN_PERIOD     = 256,
  parameter int unsigned MAX_PERIOD     = 66_000_000
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      hall_n,
  output logic                      position_sync,
  output logic [NB_SLICES_LOG2-1:0] slice_idx,
  output logic                      locked,
  output logic [PERIOD_W-1:0]       rotation_period
);

  localparam logic [PERIOD_W-1:0]       MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0]       MAX_P      = PERIOD_W'(MAX_PERIOD);
  localparam logic [NB_SLICES_LOG2-1:0] LAST_SLICE = '1;

  logic edge_c;

`ifdef ROTATION_SLICER_SIM_EN
  localparam int unsigned SIM_W = $clog2(SIM_PERIOD);
  localparam logic [SIM_W-1:0] SIM_LAST = SIM_W'(SIM_PERIOD - 1);

  logic [SIM_W-1:0] sim_cnt_q;

  // Free-running synthetic revolution; hall_n is deliberately unused here.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sim_cnt_q <= '0;
    end else if (sim_cnt_q == SIM_LAST) begin
      sim_cnt_q <= '0;
    end else begin
      sim_cnt_q <= sim_cnt_q + SIM_W'(1);
    end
  end

  assign edge_c = (sim_cnt_q == SIM_LAST);
`else
  hall_edge_detect u_hall_edge_detect (
    .clk      (clk),
    .nrst     (nrst),
    .hall_n_i (hall_n),
    .fall_c   (edge_c)
  );
`endif

  rot_state_t                state_q, state_d;
  logic [PERIOD_W-1:0]       pcnt_q, pcnt_d;
  logic [PERIOD_W-1:0]       stimer_q, stimer_d;
  logic [PERIOD_W-1:0]       period_q, period_d;
  logic [NB_SLICES_LOG2-1:0] idx_q, idx_d;
  logic                      sync_q, sync_d;
  logic                      locked_q, locked_d;

  logic [PERIOD_W-1:0] slice_period_c;
  logic                accept_c;
  logic                stall_c;

  // Slice length, never zero so the slice timer always has a target.
  always_comb begin
    slice_period_c = period_q >> NB_SLICES_LOG2;
    if (slice_period_c == '0) begin
      slice_period_c = PERIOD_W'(1);
    end
  end

  assign accept_c = edge_c & ((pcnt_q >= MIN_P) | (state_q == IDLE));
  assign stall_c  = (pcnt_q == MAX_P) & (state_q != IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      stimer_q <= '0;
      period_q <= '0;
      idx_q    <= '0;
      sync_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      stimer_q <= stimer_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      sync_q   <= sync_d;
      locked_q <= locked_d;
    end
  end

  // Stall beats everything; an accepted edge beats slice-timer expiry.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    stimer_d = stimer_q;
    period_d = period_q;
    idx_d    = idx_q;
    sync_d   = 1'b0;
    locked_d = locked_q;

    if (pcnt_q != MAX_P) begin
      pcnt_d = pcnt_q + PERIOD_W'(1);
    end

    if (stall_c) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      idx_d    = '0;
      stimer_d = '0;
    end else if (accept_c) begin
      pcnt_d = '0;
      if (state_q == IDLE) begin
        state_d = MEASURE;
      end else begin
        state_d  = LOCKED;
        period_d = pcnt_q + PERIOD_W'(1);
        locked_d = 1'b1;
        idx_d    = '0;
        stimer_d = '0;
        sync_d   = 1'b1;
      end
    end else if (state_q == LOCKED) begin
      if (stimer_q == slice_period_c - PERIOD_W'(1)) begin
        // On the last slice the motor is slow: hold and wait for the hall edge.
        if (idx_q != LAST_SLICE) begin
          stimer_d = '0;
          idx_d    = idx_q + NB_SLICES_LOG2'(1);
          sync_d   = 1'b1;
        end
      end else begin
        stimer_d = stimer_q + PERIOD_W'(1);
      end
    end
  end

  assign position_sync   = sync_q;
  assign slice_idx       = idx_q;
  assign locked          = locked_q;
  assign rotation_period = period_q;

endmodule

// File: tb/tb_rotation_slicer.sv
// Directed self-checking bench for rotation_slicer with 8 slices per revolution.
module tb_rotation_slicer;

  localparam int unsigned NB = 3;
  localparam int unsigned PW = 32;
`ifdef ROTATION_SLICER_SIM_EN
  localparam int unsigned MAXP = 100000;
`else
  localparam int unsigned MAXP = 5000;
`endif

  logic          clk = 1'b0;
  logic          nrst;
  logic          hall_n;
  logic          position_sync;
  logic [NB-1:0] slice_idx;
  logic          locked;
  logic [PW-1:0] rotation_period;

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   dbl_cnt = 0;
  int   b       = 0;
  logic prev_sync = 1'b0;
  int   plog_t[$];
  int   plog_i[$];

  rotation_slicer #(
    .NB_SLICES_LOG2 (NB),
    .PERIOD_W       (PW),
    .MIN_PERIOD     (16),
    .MAX_PERIOD     (MAXP)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .hall_n          (hall_n),
    .position_sync   (position_sync),
    .slice_idx       (slice_idx),
    .locked          (locked),
    .rotation_period (rotation_period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log: cycle number of the edge that raised position_sync, and the index.
  always @(negedge clk) begin
    if (position_sync) begin
      plog_t.push_back(cyc);
      plog_i.push_back(int'(slice_idx));
    end
    if (position_sync && prev_sync) dbl_cnt <= dbl_cnt + 1;
    prev_sync <= position_sync;
  end

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    plog_t.delete();
    plog_i.delete();
  endtask

  task automatic hall_fall_at(input int c);
    go(c);
    hall_n = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 hall_n = 1'b1;
      end
    join_none
  endtask

  task automatic test_reset();
    nrst   = 1'b0;
    hall_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (position_sync !== 1'b0) begin errors++; $display("FAIL reset_sync got %0d exp 0", position_sync); end
    checks++; if (slice_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", slice_idx); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0d exp 0", locked); end
    checks++; if (rotation_period !== 32'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", rotation_period); end
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_lock();
    int n;
    b = cyc + 2;
    clear_log();
    hall_fall_at(b);
    go(b + 3);
    checks++; if (locked !== 1'b0 || position_sync !== 1'b0) begin errors++; $display("FAIL lock_first_edge got locked=%0d sync=%0d exp 0 0", locked, position_sync); end
    hall_fall_at(b + 800);
    go(b + 802);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %0d exp 0", locked); end
    go(b + 803);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked got %0d exp 1", locked); end
    checks++; if (position_sync !== 1'b1) begin errors++; $display("FAIL lock_sync got %0d exp 1", position_sync); end
    checks++; if (slice_idx !== 3'd0) begin errors++; $display("FAIL lock_idx got %0d exp 0", slice_idx); end
    checks++; if (rotation_period !== 32'd800) begin errors++; $display("FAIL lock_period got %0d exp 800", rotation_period); end
    go(b + 1550);
    checks++; if (plog_t.size() != 8) begin errors++; $display("FAIL lock_npulses got %0d exp 8", plog_t.size()); end
    n = (plog_t.size() < 8) ? plog_t.size() : 8;
    for (int k = 0; k < n; k++) begin
      checks++; if (plog_t[k] != b + 803 + 100 * k) begin errors++; $display("FAIL lock_pulse_time[%0d] got %0d exp %0d", k, plog_t[k] - b, 803 + 100 * k); end
      checks++; if (plog_i[k] != k) begin errors++; $display("FAIL lock_pulse_idx[%0d] got %0d exp %0d", k, plog_i[k], k); end
    end
  endtask

  task automatic test_glitch();
    clear_log();
    hall_fall_at(b + 1600);
    hall_fall_at(b + 1610);
    go(b + 1620);
    checks++; if (plog_t.size() != 1) begin errors++; $display("FAIL glitch_npulses got %0d exp 1", plog_t.size()); end
    if (plog_t.size() > 0) begin
      checks++; if (plog_t[0] != b + 1603) begin errors++; $display("FAIL glitch_resync_time got %0d exp 1603", plog_t[0] - b); end
    end
    checks++; if (slice_idx !== 3'd0) begin errors++; $display("FAIL glitch_idx got %0d exp 0", slice_idx); end
    checks++; if (rotation_period !== 32'd800) begin errors++; $display("FAIL glitch_period got %0d exp 800", rotation_period); end
    go(b + 1703);
    checks++; if (position_sync !== 1'b1 || slice_idx !== 3'd1) begin errors++; $display("FAIL glitch_next got sync=%0d idx=%0d exp 1 1", position_sync, slice_idx); end
  endtask

  task automatic test_slowdown();
    go(b + 2310);
    clear_log();
    hall_fall_at(b + 2600);
    go(b + 2602);
    checks++; if (plog_t.size() != 0) begin errors++; $display("FAIL slow_hold_pulses got %0d exp 0", plog_t.size()); end
    checks++; if (slice_idx !== 3'd7) begin errors++; $display("FAIL slow_hold_idx got %0d exp 7", slice_idx); end
    go(b + 2603);
    checks++; if (position_sync !== 1'b1 || slice_idx !== 3'd0) begin errors++; $display("FAIL slow_resync got sync=%0d idx=%0d exp 1 0", position_sync, slice_idx); end
    checks++; if (rotation_period !== 32'd1000) begin errors++; $display("FAIL slow_period got %0d exp 1000", rotation_period); end
    go(b + 2728);
    checks++; if (position_sync !== 1'b1 || slice_idx !== 3'd1) begin errors++; $display("FAIL slow_next got sync=%0d idx=%0d exp 1 1", position_sync, slice_idx); end
  endtask

  task automatic test_collision();
    // Hall edge lands exactly where slice 5 -> 6 would have pulsed.
    go(b + 3343);
    clear_log();
    hall_fall_at(b + 3350);
    go(b + 3363);
    checks++; if (plog_t.size() != 1) begin errors++; $display("FAIL coll_npulses got %0d exp 1", plog_t.size()); end
    if (plog_t.size() > 0) begin
      checks++; if (plog_t[0] != b + 3353 || plog_i[0] != 0) begin errors++; $display("FAIL coll_pulse got t=%0d idx=%0d exp 3353 0", plog_t[0] - b, plog_i[0]); end
    end
    checks++; if (rotation_period !== 32'd750) begin errors++; $display("FAIL coll_period got %0d exp 750", rotation_period); end
    go(b + 3446);
    checks++; if (position_sync !== 1'b1 || slice_idx !== 3'd1) begin errors++; $display("FAIL coll_next got sync=%0d idx=%0d exp 1 1", position_sync, slice_idx); end
  endtask

  task automatic test_stall();
    int f;
    go(b + 3353 + 4990);
    checks++; if (locked !== 1'b1 || slice_idx !== 3'd7) begin errors++; $display("FAIL stall_before got locked=%0d idx=%0d exp 1 7", locked, slice_idx); end
    go(b + 3353 + 5010);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL stall_locked got %0d exp 0", locked); end
    checks++; if (slice_idx !== 3'd0) begin errors++; $display("FAIL stall_idx got %0d exp 0", slice_idx); end
    clear_log();
    f = b + 8453;
    go(f);
    checks++; if (plog_t.size() != 0) begin errors++; $display("FAIL stall_pulses got %0d exp 0", plog_t.size()); end
    hall_fall_at(f);
    go(f + 3);
    checks++; if (locked !== 1'b0 || position_sync !== 1'b0) begin errors++; $display("FAIL stall_one_edge got locked=%0d sync=%0d exp 0 0", locked, position_sync); end
    hall_fall_at(f + 400);
    go(f + 403);
    checks++; if (locked !== 1'b1 || position_sync !== 1'b1 || slice_idx !== 3'd0) begin errors++; $display("FAIL stall_relock got locked=%0d sync=%0d idx=%0d exp 1 1 0", locked, position_sync, slice_idx); end
    checks++; if (rotation_period !== 32'd400) begin errors++; $display("FAIL stall_period got %0d exp 400", rotation_period); end
  endtask

  task automatic test_reset_mid();
    int f;
    int r;
    f = b + 8453;
    go(f + 520);
    nrst = 1'b0;
    #1;
    checks++; if (position_sync !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL rmid_flags got sync=%0d locked=%0d exp 0 0", position_sync, locked); end
    checks++; if (slice_idx !== 3'd0) begin errors++; $display("FAIL rmid_idx got %0d exp 0", slice_idx); end
    checks++; if (rotation_period !== 32'd0) begin errors++; $display("FAIL rmid_period got %0d exp 0", rotation_period); end
    go(f + 525);
    nrst = 1'b1;
    r = f + 530;
    hall_fall_at(r);
    go(r + 3);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rmid_one_edge got %0d exp 0", locked); end
    hall_fall_at(r + 300);
    go(r + 303);
    checks++; if (locked !== 1'b1 || position_sync !== 1'b1) begin errors++; $display("FAIL rmid_relock got locked=%0d sync=%0d exp 1 1", locked, position_sync); end
    checks++; if (rotation_period !== 32'd300) begin errors++; $display("FAIL rmid_period2 got %0d exp 300", rotation_period); end
  endtask

`ifdef ROTATION_SLICER_SIM_EN
  task automatic test_sim();
    int n;
    n = 0;
    while (locked !== 1'b1 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sim_lock_timeout got %0d exp 1", locked); end
    checks++; if (n < 16800 || n > 17000) begin errors++; $display("FAIL sim_lock_time got %0d exp about 16896", n); end
    checks++; if (rotation_period !== 32'd8448) begin errors++; $display("FAIL sim_period got %0d exp 8448", rotation_period); end
    clear_log();
    repeat (2200) @(posedge clk);
    #1;
    checks++; if (plog_t.size() < 2) begin errors++; $display("FAIL sim_npulses got %0d exp 2", plog_t.size()); end
    if (plog_t.size() >= 2) begin
      checks++; if (plog_t[1] - plog_t[0] != 1056) begin errors++; $display("FAIL sim_spacing got %0d exp 1056", plog_t[1] - plog_t[0]); end
    end
  endtask
`endif

  task automatic test_no_double();
    checks++; if (dbl_cnt != 0) begin errors++; $display("FAIL no_double got %0d exp 0", dbl_cnt); end
  endtask

  initial begin
    test_reset();
`ifdef ROTATION_SLICER_SIM_EN
    test_sim();
`else
    test_lock();
    test_glitch();
    test_slowdown();
    test_collision();
    test_stall();
    test_reset_mid();
`endif
    test_no_double();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
